// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter: shares one data-memory port between the CPU and the display
// scanner, with bounded scanner wait and a CPU lock. Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int DW       = 40,
  parameter int AW       = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_lock,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_gnt,
  output logic          scan_rvalid,
  output logic [DW-1:0] scan_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [3:0] r_wait_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: lock release takes effect at the edge, so the release cycle
  // itself is still arbitrated under LOCKED rules.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cpu_gnt && cpu_lock) w_state_nxt = S_LOCKED;
      S_LOCKED: if (!cpu_lock)           w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Grant decision
  always_comb begin
    cpu_gnt  = 1'b0;
    scan_gnt = 1'b0;
    case (r_state)
      S_LOCKED: cpu_gnt = cpu_req;
      default: begin
        if (scan_req && (r_wait_cnt == c_max_wait)) scan_gnt = 1'b1;
        else if (cpu_req)                           cpu_gnt  = 1'b1;
        else if (scan_req)                          scan_gnt = 1'b1;
      end
    endcase
  end

  assign mem_addr  = scan_gnt ? scan_addr : cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_we    = cpu_gnt & cpu_we;

  // Scanner starvation counter keeps counting while the CPU holds the lock.
  always_ff @(posedge clk) begin
    if (rst || scan_gnt || !scan_req) r_wait_cnt <= 4'd0;
    else if (r_wait_cnt != c_max_wait) r_wait_cnt <= r_wait_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      scan_rvalid <= 1'b0;
      scan_rdata  <= '0;
    end else begin
      cpu_rvalid  <= cpu_gnt & ~cpu_we;
      scan_rvalid <= scan_gnt;
      if (cpu_gnt && !cpu_we) cpu_rdata  <= mem_rdata;
      if (scan_gnt)           scan_rdata <= mem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a
// behavioural arbitration/memory model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int DW       = 40;
  localparam int AW       = 4;
  localparam int MAX_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_gnt, scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_gnt(scan_gnt), .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Memory attached to the arbiter: combinational read, write at clock edge
  logic [DW-1:0] mem [16];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model
  logic [DW-1:0] ref_mem [16];
  bit            m_known;
  bit            m_locked;
  int            m_waited;
  bit            m_cpu_rvalid, m_scan_rvalid;
  logic [DW-1:0] m_cpu_rdata, m_scan_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit creq, input bit cwe, input bit clk_lock,
                      input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                      input bit sreq, input logic [AW-1:0] saddr);
    bit ecg, esg;
    @(negedge clk);
    rst = r; cpu_req = creq; cpu_we = cwe; cpu_lock = clk_lock;
    cpu_addr = caddr; cpu_wdata = cwd; scan_req = sreq; scan_addr = saddr;
    #1;
    // Who should win this cycle
    if (m_locked) begin
      ecg = creq; esg = 1'b0;
    end else if (sreq && m_waited >= MAX_WAIT) begin
      ecg = 1'b0; esg = 1'b1;
    end else begin
      ecg = creq; esg = sreq && !creq;
    end
    if (m_known) begin
      check("cpu_gnt", 64'(cpu_gnt), 64'(ecg));
      check("scan_gnt", 64'(scan_gnt), 64'(esg));
      check("mem_we", 64'(mem_we), 64'(ecg && cwe));
      if (esg) check("mem_addr_scan", 64'(mem_addr), 64'(saddr));
      if (ecg) check("mem_addr_cpu", 64'(mem_addr), 64'(caddr));
      if (ecg && cwe) check("mem_wdata", 64'(mem_wdata), 64'(cwd));
      check("cpu_rvalid", 64'(cpu_rvalid), 64'(m_cpu_rvalid));
      check("scan_rvalid", 64'(scan_rvalid), 64'(m_scan_rvalid));
      check("cpu_rdata", 64'(cpu_rdata), 64'(m_cpu_rdata));
      check("scan_rdata", 64'(scan_rdata), 64'(m_scan_rdata));
    end
    // Advance the model to the state after this cycle's clock edge
    if (r) begin
      m_known = 1'b1; m_locked = 1'b0; m_waited = 0;
      m_cpu_rvalid = 1'b0; m_scan_rvalid = 1'b0;
      m_cpu_rdata = '0; m_scan_rdata = '0;
    end else begin
      m_cpu_rvalid  = ecg && !cwe;
      m_scan_rvalid = esg;
      if (ecg && !cwe) m_cpu_rdata  = ref_mem[caddr];
      if (esg)         m_scan_rdata = ref_mem[saddr];
      if (m_locked) m_locked = clk_lock;
      else          m_locked = ecg && clk_lock;
      if (esg || !sreq) m_waited = 0;
      else if (m_waited < MAX_WAIT) m_waited++;
    end
    if (ecg && cwe) ref_mem[caddr] = cwd;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {8'($urandom), $urandom};
  endfunction

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; scan_req = 1'b0; scan_addr = '0;
    m_known = 1'b0; m_locked = 1'b0; m_waited = 0;
    m_cpu_rvalid = 1'b0; m_scan_rvalid = 1'b0; m_cpu_rdata = '0; m_scan_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] w;
      w = rnd_word();
      mem[i] = w; ref_mem[i] = w;
    end

    // Reset with both requests high, then first grant to CPU
    step(1, 1, 0, 0, 4'd1, '0, 1, 4'd2);
    step(1, 1, 0, 0, 4'd1, '0, 1, 4'd2);
    step(0, 1, 0, 0, 4'd1, '0, 1, 4'd2);
    step(0, 0, 0, 0, 4'd0, '0, 0, 4'd0);

    // Write then read back address 3
    step(0, 1, 1, 0, 4'd3, 40'h12_3456_789A, 0, 4'd0);
    step(0, 1, 0, 0, 4'd3, '0, 0, 4'd0);
    step(0, 0, 0, 0, 4'd0, '0, 0, 4'd0);
    check("rdata_addr3", 64'(cpu_rdata), 64'h12_3456_789A);

    // Continuous contention: C,C,C,S pattern
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 4'(i), '0, 1, 4'(i + 5));
    step(0, 0, 0, 0, 4'd0, '0, 0, 4'd0);

    // Lock across 6 CPU accesses with scanner waiting, then release
    for (int i = 0; i < 6; i++) step(0, 1, i[0], 1, 4'(i), rnd_word(), 1, 4'd9);
    step(0, 1, 0, 0, 4'd7, '0, 1, 4'd9);
    step(0, 1, 0, 0, 4'd7, '0, 1, 4'd9);
    step(0, 0, 0, 0, 4'd0, '0, 0, 4'd0);

    // Locked with CPU idle for 2 cycles
    step(0, 1, 1, 1, 4'd4, rnd_word(), 0, 4'd0);
    step(0, 0, 1, 1, 4'd4, rnd_word(), 1, 4'd8);
    step(0, 0, 1, 1, 4'd4, rnd_word(), 1, 4'd8);
    step(0, 1, 0, 1, 4'd4, '0, 1, 4'd8);
    step(0, 1, 0, 0, 4'd4, '0, 1, 4'd8);
    step(0, 0, 0, 0, 4'd0, '0, 0, 4'd0);

    // Reset sampled at the edge ending a scan grant drops the read
    step(0, 0, 0, 0, 4'd0, '0, 1, 4'd6);
    step(1, 0, 0, 0, 4'd0, '0, 1, 4'd6);
    step(0, 0, 0, 0, 4'd0, '0, 0, 4'd0);
    check("scan_rvalid_after_rst", 64'(scan_rvalid), 64'd0);
    check("scan_rdata_after_rst", 64'(scan_rdata), 64'd0);

    // Randomized traffic
    begin
      bit lk;
      lk = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) lk = ~lk;
        step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             lk, 4'($urandom), rnd_word(), $urandom_range(0, 2) != 0, 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
